ex_muldiv_ctrl: RTL

- Sequencer for the EX-stage multiply/divide resource: accepts MULT/MULTU/DIV/DIVU from ID/EX and owns the HI/LO registers.
- Runs one shared 33-bit add/sub datapath iteratively, one bit per cycle.
- Raises a pipeline stall while busy so dependent ops and mfhi/mflo wait; issuing ops beside the single-cycle ALU.

---
 rtl/ex_pkg.sv | 35 +++
 rtl/ex_muldiv_ctrl_if.sv | 32 +++
 rtl/muldiv_step.sv | 36 +++
 rtl/ex_muldiv_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and defaults for the EX multiply/divide sequencer
package ex_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Step modes: pass-through, conditional add (multiply), restoring subtract (divide)
    typedef enum logic [1:0] {
        M_PASS = 2'd0,
        M_ADD  = 2'd1,
        M_SUB  = 2'd2
    } step_mode_t;

    function automatic logic op_is_div(input op_t op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// rtl/ex_muldiv_ctrl_if.sv - ID/EX request, HI/LO access and status bundle
interface ex_muldiv_ctrl_if #(parameter int XLEN = ex_pkg::XLEN_DEF);
    import ex_pkg::*;

    logic            i_start;
    op_t             i_op;
    logic [XLEN-1:0] i_rs_data;
    logic [XLEN-1:0] i_rt_data;
    logic            i_hilo_rd;
    logic            i_hi_we;
    logic            i_lo_we;
    logic [XLEN-1:0] i_wdata;
    logic            i_flush;
    logic [XLEN-1:0] o_hi;
    logic [XLEN-1:0] o_lo;
    logic            o_busy;
    logic            o_stall;
    logic            o_done;

    modport master (
        output i_start, i_op, i_rs_data, i_rt_data, i_hilo_rd,
               i_hi_we, i_lo_we, i_wdata, i_flush,
        input  o_hi, o_lo, o_busy, o_stall, o_done
    );

    modport slave (
        input  i_start, i_op, i_rs_data, i_rt_data, i_hilo_rd,
               i_hi_we, i_lo_we, i_wdata, i_flush,
        output o_hi, o_lo, o_busy, o_stall, o_done
    );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of the shared 33-bit add/sub datapath
module muldiv_step
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN:0]   i_partial,
    input  logic [XLEN-1:0] i_operand,
    input  step_mode_t      i_mode,
    output logic [XLEN:0]   o_partial,
    output logic            o_qbit
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_diff;

    assign w_sum  = i_partial + {1'b0, i_operand};
    assign w_diff = i_partial - {1'b0, i_operand};

    // A clear top bit of the difference means no borrow: keep it and emit a 1
    always_comb begin
        o_partial = i_partial;
        o_qbit    = 1'b0;
        case (i_mode)
            M_ADD: o_partial = w_sum;
            M_SUB: begin
                if (!w_diff[XLEN]) begin
                    o_partial = w_diff;
                    o_qbit    = 1'b1;
                end
            end
            default: o_partial = i_partial;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - iterative MULT/DIV sequencer owning HI/LO with pipeline stall
module ex_muldiv_ctrl
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_muldiv_ctrl_if.slave bus
);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    op_t             r_op;
    logic [XLEN-1:0] r_a_raw;
    logic [XLEN-1:0] r_b_raw;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_done;

    logic            w_busy;
    logic            w_accept;
    logic            w_is_div;
    logic            w_b_zero;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN:0]   w_step_in;
    logic [XLEN:0]   w_step_out;
    logic            w_qbit;
    step_mode_t      w_mode;
    logic [XLEN-1:0] w_acc_next;
    logic [XLEN-1:0] w_q_next;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_fix_hi;
    logic [XLEN-1:0] w_fix_lo;

    assign w_busy   = (r_state != S_IDLE);
    assign w_accept = (r_state == S_IDLE) && bus.i_start && !bus.i_flush;
    assign w_is_div = op_is_div(r_op);
    assign w_b_zero = (r_b_raw == '0);
    assign w_sa     = op_is_signed(r_op) & r_a_raw[XLEN-1];
    assign w_sb     = op_is_signed(r_op) & r_b_raw[XLEN-1];
    assign w_abs_a  = w_sa ? -r_a_raw : r_a_raw;
    assign w_abs_b  = w_sb ? -r_b_raw : r_b_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.i_flush && w_busy) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_next = S_PREP;
                S_PREP: w_next = (w_is_div && w_b_zero) ? S_FIX : S_ITER;
                S_ITER: if (r_cnt == CW'(XLEN - 1)) w_next = S_FIX;
                S_FIX:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Multiply shifts {acc,q} right with the multiplier in q; divide shifts the
    // dividend out of q's MSB into acc and the quotient bits in at q's LSB
    always_comb begin
        w_step_in = {1'b0, r_acc};
        w_mode    = M_PASS;
        if (w_is_div) begin
            w_step_in = {r_acc, r_q[XLEN-1]};
            w_mode    = M_SUB;
        end else if (r_q[0]) begin
            w_mode    = M_ADD;
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_partial (w_step_in),
        .i_operand (r_opnd),
        .i_mode    (w_mode),
        .o_partial (w_step_out),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_acc_next = w_step_out[XLEN:1];
        w_q_next   = {w_step_out[0], r_q[XLEN-1:1]};
        if (w_is_div) begin
            w_acc_next = w_step_out[XLEN-1:0];
            w_q_next   = {r_q[XLEN-2:0], w_qbit};
        end
    end

    always_comb begin
        w_prod   = {r_acc, r_q};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_fix_hi = w_prod_s[2*XLEN-1:XLEN];
        w_fix_lo = w_prod_s[XLEN-1:0];
        if (w_is_div) begin
            if (w_b_zero) begin
                w_fix_lo = '1;
                w_fix_hi = r_a_raw;
            end else begin
                w_fix_lo = r_neg_q ? -r_q : r_q;
                w_fix_hi = r_neg_r ? -r_acc : r_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op    <= OP_MULTU;
            r_a_raw <= '0;
            r_b_raw <= '0;
            r_opnd  <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_hi_we) r_hi <= bus.i_wdata;
                    if (bus.i_lo_we) r_lo <= bus.i_wdata;
                    if (w_accept) begin
                        r_op    <= bus.i_op;
                        r_a_raw <= bus.i_rs_data;
                        r_b_raw <= bus.i_rt_data;
                    end
                end
                S_PREP: begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_neg_q <= w_sa ^ w_sb;
                    r_neg_r <= w_sa;
                    if (w_is_div) begin
                        r_q    <= w_abs_a;
                        r_opnd <= w_abs_b;
                    end else begin
                        r_q    <= w_abs_b;
                        r_opnd <= w_abs_a;
                    end
                end
                S_ITER: begin
                    r_acc <= w_acc_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    if (!bus.i_flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign bus.o_hi    = r_hi;
    assign bus.o_lo    = r_lo;
    assign bus.o_busy  = w_busy;
    assign bus.o_stall = w_busy & (bus.i_start | bus.i_hilo_rd | bus.i_hi_we | bus.i_lo_we);
    assign bus.o_done  = r_done;

endmodule
